// File: rtl/fetch_queue_pkg.sv
// Shared widths, default reset PC and the packed fetch-entry type used by
// the prefetch queue and its FIFO.
package fetch_queue_pkg;

    localparam int INST_W = 32;
    localparam int PC_W   = 32;

    localparam logic [PC_W-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

    typedef struct packed {
        logic [INST_W-1:0] inst;
        logic [PC_W-1:0]   pc;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Small circular FIFO of fetch entries. The head is read straight from storage
// so a pushed word is visible the cycle after it is written. Empty reads as zero.
module fetch_fifo
    import fetch_queue_pkg::*;
#(
    parameter int  DEPTH   = 4,
    parameter type entry_t = fetch_entry_t
)(
    input  logic                   clk,
    input  logic                   srst,
    input  logic                   i_flush,
    input  logic                   i_push,
    input  entry_t                 i_push_data,
    input  logic                   i_pop,
    output entry_t                 o_head,
    output logic [$clog2(DEPTH):0] o_count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    entry_t          r_mem [DEPTH];
    logic [PW-1:0]   r_wr_ptr;
    logic [PW-1:0]   r_rd_ptr;
    logic [CW-1:0]   r_count;
    logic            w_push_en;
    logic            w_pop_en;
    logic [DEPTH-1:0] w_we;

    assign w_push_en = i_push && !i_flush;
    assign w_pop_en  = i_pop && !i_flush && (r_count != '0);

    // Storage carries no reset; the count gates what is visible.
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
        assign w_we[gi] = w_push_en && (r_wr_ptr == PW'(gi));
        always_ff @(posedge clk) begin
            if (w_we[gi]) begin
                r_mem[gi] <= i_push_data;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (srst || i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push_en) begin
                r_wr_ptr <= r_wr_ptr + PW'(1);
            end
            if (w_pop_en) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
            case ({w_push_en, w_pop_en})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!srst) begin
            assert (!(w_push_en && (r_count == CW'(DEPTH))));
        end
    end

    assign o_head  = (r_count != '0) ? r_mem[r_rd_ptr] : '0;
    assign o_count = r_count;

endmodule

// File: rtl/fetch_queue.sv
// Instruction prefetch: owns the fetch PC, issues one word fetch per cycle while
// credits remain, and buffers returned words with their PCs for decode.
module fetch_queue
    import fetch_queue_pkg::*;
#(
    parameter int              DEPTH    = 4,
    parameter logic [PC_W-1:0] RESET_PC = RESET_PC_DEFAULT
)(
    input  logic              clk,
    input  logic              rst,
    output logic              imem_req,
    output logic [PC_W-1:0]   imem_addr,
    input  logic [INST_W-1:0] imem_rdata,
    input  logic              redirect,
    input  logic [PC_W-1:0]   redirect_pc,
    output logic [INST_W-1:0] inst,
    output logic [PC_W-1:0]   inst_pc,
    output logic              inst_valid,
    input  logic              inst_ready
);

    localparam int CW = $clog2(DEPTH) + 1;

    logic [PC_W-1:0] r_pc;
    logic            r_inflight;
    logic [PC_W-1:0] r_inflight_pc;

    logic [CW-1:0]   w_count;
    logic [CW:0]     w_used;
    logic            w_push;
    logic            w_pop;
    logic [PC_W-1:0] w_redirect_pc;
    fetch_entry_t    w_push_data;
    fetch_entry_t    w_head;

    // Credits count the in-flight word, so the FIFO can never be overrun.
    // A pop this cycle only frees its slot for next cycle's request.
    assign w_used   = {1'b0, w_count} + {{CW{1'b0}}, r_inflight};
    assign imem_req = !rst && !redirect && (w_used < (CW+1)'(DEPTH));
    assign imem_addr = r_pc;

    assign w_redirect_pc = redirect_pc & ~32'h0000_0003;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc          <= RESET_PC;
            r_inflight    <= 1'b0;
            r_inflight_pc <= '0;
        end else if (redirect) begin
            r_pc       <= w_redirect_pc;
            r_inflight <= 1'b0;
        end else begin
            r_inflight <= imem_req;
            if (imem_req) begin
                r_pc          <= r_pc + 32'd4;
                r_inflight_pc <= r_pc;
            end
        end
    end

    // The response landing in a redirect cycle belongs to the old stream.
    assign w_push           = r_inflight && !redirect;
    assign w_push_data.inst = imem_rdata;
    assign w_push_data.pc   = r_inflight_pc;
    assign w_pop            = inst_valid && inst_ready;

    fetch_fifo #(
        .DEPTH   (DEPTH),
        .entry_t (fetch_entry_t)
    ) u_fifo (
        .clk         (clk),
        .srst        (rst),
        .i_flush     (redirect),
        .i_push      (w_push),
        .i_push_data (w_push_data),
        .i_pop       (w_pop),
        .o_head      (w_head),
        .o_count     (w_count)
    );

    assign inst_valid = (w_count != '0);
    assign inst       = w_head.inst;
    assign inst_pc    = w_head.pc;

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue: fetch latency, backpressure, redirects,
// mid-run reset and PC wrap, against a one-cycle-latency instruction memory.
module tb_fetch_queue;

    logic        clk;
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        inst_valid;
    logic        inst_ready;

    int total = 0;
    int bad   = 0;

    fetch_queue #(
        .DEPTH    (4),
        .RESET_PC (32'h0000_0000)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_rdata  (imem_rdata),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .inst        (inst),
        .inst_pc     (inst_pc),
        .inst_valid  (inst_valid),
        .inst_ready  (inst_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory word at byte address a is 0x100 + a/4; idle cycles return garbage.
    always @(posedge clk) begin
        imem_rdata <= imem_req ? (32'h100 + (imem_addr >> 2)) : 32'hDEAD_BEEF;
    end

    function automatic logic [31:0] word_at(input logic [31:0] pc);
        return 32'h100 + (pc >> 2);
    endfunction

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_head(input string tag, input logic [31:0] pc);
        chk({tag, "_valid"}, {31'b0, inst_valid}, 32'd1);
        chk({tag, "_pc"}, inst_pc, pc);
        chk({tag, "_inst"}, inst, word_at(pc));
    endtask

    initial begin
        rst         = 1'b1;
        redirect    = 1'b0;
        redirect_pc = 32'h0;
        inst_ready  = 1'b0;

        // Reset state
        cyc(); cyc(); #1;
        chk("rst_req",   {31'b0, imem_req},   32'd0);
        chk("rst_valid", {31'b0, inst_valid}, 32'd0);
        chk("rst_inst",  inst,                32'd0);
        chk("rst_pc",    inst_pc,             32'd0);
        chk("rst_addr",  imem_addr,           32'd0);

        // Release: first request immediately, first word two cycles later
        cyc(); rst = 1'b0; inst_ready = 1'b1; #1;
        chk("c0_req",   {31'b0, imem_req},   32'd1);
        chk("c0_addr",  imem_addr,           32'd0);
        chk("c0_valid", {31'b0, inst_valid}, 32'd0);
        cyc(); #1;
        chk("c1_valid", {31'b0, inst_valid}, 32'd0);
        chk("c1_addr",  imem_addr,           32'd4);
        for (int k = 2; k <= 5; k++) begin
            cyc(); #1;
            chk_head("stream", 32'(4 * (k - 2)));
        end

        // Backpressure: queue fills, requests stop
        cyc(); inst_ready = 1'b0; #1;
        chk_head("bp_c6", 32'd16);
        for (int k = 7; k <= 15; k++) begin
            cyc(); #1;
            chk("bp_hold_pc", inst_pc, 32'd16);
            if (k >= 8) chk("bp_req_low", {31'b0, imem_req}, 32'd0);
        end
        chk("bp_addr", imem_addr, 32'd32);

        // Release: the first pop frees a credit only the next cycle
        cyc(); inst_ready = 1'b1; #1;
        chk("rel_req0", {31'b0, imem_req}, 32'd0);
        chk_head("rel_c16", 32'd16);
        cyc(); #1;
        chk("rel_req1", {31'b0, imem_req}, 32'd1);
        chk("rel_addr", imem_addr, 32'd32);
        chk_head("rel_c17", 32'd20);
        for (int k = 18; k <= 21; k++) begin
            cyc(); #1;
            chk_head("rel_stream", 32'(16 + 4 * (k - 16)));
        end

        // Redirect with three queued entries and one in flight
        cyc(); inst_ready = 1'b0; #1;
        chk_head("pre_redir", 32'd40);
        cyc(); redirect = 1'b1; redirect_pc = 32'h43; #1;
        chk("redir_req", {31'b0, imem_req}, 32'd0);
        cyc(); redirect = 1'b0; inst_ready = 1'b1; #1;
        chk("redir_r1_req",   {31'b0, imem_req},   32'd1);
        chk("redir_r1_addr",  imem_addr,           32'h40);
        chk("redir_r1_valid", {31'b0, inst_valid}, 32'd0);
        cyc(); #1;
        chk("redir_r2_valid", {31'b0, inst_valid}, 32'd0);
        cyc(); #1;
        chk_head("redir_r3", 32'h40);
        cyc(); #1;
        chk_head("redir_r4", 32'h44);

        // Redirect while popping, then a second redirect the next cycle
        cyc(); redirect = 1'b1; redirect_pc = 32'h200; #1;
        chk_head("dbl_pop", 32'h48);
        chk("dbl_req0", {31'b0, imem_req}, 32'd0);
        cyc(); redirect_pc = 32'h80; #1;
        chk("dbl_req1",   {31'b0, imem_req},   32'd0);
        chk("dbl_valid1", {31'b0, inst_valid}, 32'd0);
        cyc(); redirect = 1'b0; #1;
        chk("dbl_req2",   {31'b0, imem_req},   32'd1);
        chk("dbl_addr2",  imem_addr,           32'h80);
        chk("dbl_valid2", {31'b0, inst_valid}, 32'd0);
        cyc(); #1;
        chk("dbl_valid3", {31'b0, inst_valid}, 32'd0);
        for (int k = 32; k <= 34; k++) begin
            cyc(); #1;
            chk_head("dbl_stream", 32'(32'h80 + 4 * (k - 32)));
        end

        // Fill the queue, then reset for one cycle
        cyc(); inst_ready = 1'b0;
        for (int k = 0; k < 6; k++) cyc();
        #1;
        chk("full_req", {31'b0, imem_req}, 32'd0);
        chk_head("full_head", 32'h8C);
        cyc(); rst = 1'b1; #1;
        chk("mrst_req", {31'b0, imem_req}, 32'd0);
        cyc(); rst = 1'b0; inst_ready = 1'b1; #1;
        chk("mrst_valid", {31'b0, inst_valid}, 32'd0);
        chk("mrst_inst",  inst,                32'd0);
        chk("mrst_pc",    inst_pc,             32'd0);
        chk("mrst_addr",  imem_addr,           32'd0);
        chk("mrst_req1",  {31'b0, imem_req},   32'd1);
        cyc(); #1;
        chk("mrst_valid1", {31'b0, inst_valid}, 32'd0);
        cyc(); #1;
        chk_head("mrst_first", 32'd0);

        // PC wrap at the top of the address space
        cyc(); redirect = 1'b1; redirect_pc = 32'hFFFF_FFFC; #1;
        cyc(); redirect = 1'b0; #1;
        chk("wrap_addr0", imem_addr, 32'hFFFF_FFFC);
        chk("wrap_req0",  {31'b0, imem_req}, 32'd1);
        cyc(); #1;
        chk("wrap_addr1", imem_addr, 32'h0000_0000);
        cyc(); #1;
        chk_head("wrap_top", 32'hFFFF_FFFC);
        cyc(); #1;
        chk_head("wrap_zero", 32'h0000_0000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
